// File: rtl/coinc_pkg.sv
// Shared state type and shot-length helper for the coincidence pulse generator.
package coinc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAP,
      DONE
   } pulsegen_state_t;

   // Cycles per shot: the shot timer is NBITS+1 bits wide and runs its full range.
   function automatic int unsigned span(input int unsigned nbits);
      return 32'd1 << (nbits + 32'd1);
   endfunction

endpackage

// File: rtl/coincidence_pulse_gen_if.sv
// Burst control inputs and channel/status outputs of the coincidence pulse generator.
interface coincidence_pulse_gen_if #(
   parameter int unsigned NCHAN = 4,
   parameter int unsigned NBITS = 4
);

   logic                         Start;
   logic                         Stop;
   logic [NCHAN-1:0]             Mask;
   logic [NCHAN-1:0][NBITS-1:0]  Offsets;
   logic [NBITS-1:0]             Width;
   logic [NBITS-1:0]             Gap;
   logic [NBITS-1:0]             Shots;
   logic [NCHAN-1:0]             Channels;
   logic                         Busy;
   logic                         Done;
   logic [NBITS-1:0]             ShotCount;

   modport master (
      output Start, Stop, Mask, Offsets, Width, Gap, Shots,
      input  Channels, Busy, Done, ShotCount
   );

   modport slave (
      input  Start, Stop, Mask, Offsets, Width, Gap, Shots,
      output Channels, Busy, Done, ShotCount
   );

endinterface

// File: rtl/pulse_window.sv
// One output channel: registered high while the shot timer lies in [offset, offset+width).
module pulse_window #(
   parameter int unsigned NBITS = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             en,
   input  logic [NBITS:0]   t,
   input  logic [NBITS-1:0] offset,
   input  logic [NBITS-1:0] width,
   input  logic             mask,
   output logic             ch
);

   localparam int unsigned TW = NBITS + 1;

   logic [TW-1:0] lo_c;
   logic [TW-1:0] hi_c;

   // The extra timer bit keeps offset+width from wrapping, so a pulse always ends inside its shot.
   assign lo_c = TW'(offset);
   assign hi_c = TW'(offset) + TW'(width);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ch <= 1'b0;
      end else begin
         ch <= en && mask && (t >= lo_c) && (t < hi_c);
      end
   end

endmodule

// File: rtl/coincidence_pulse_gen.sv
// Burst pulse generator driving a coincidence detector's channel bus with masked, offset pulses.
// Macro PULSEGEN_SHOTCNT_EN builds the ShotCount register; otherwise a down-counter ends the burst.
module coincidence_pulse_gen
   import coinc_pkg::*;
#(
   parameter int unsigned NCHAN = 4,
   parameter int unsigned NBITS = 4
) (
   input  logic                    Clk,
   input  logic                    Rst_n,
   coincidence_pulse_gen_if.slave  bus
);

   localparam int unsigned    TW     = NBITS + 1;
   localparam logic [TW-1:0]  T_LAST = TW'(span(NBITS) - 32'd1);

   pulsegen_state_t             state_q;
   pulsegen_state_t             state_d;
   logic [NCHAN-1:0]            mask_q;
   logic [NCHAN-1:0][NBITS-1:0] offsets_q;
   logic [NBITS-1:0]            width_q;
   logic [NBITS-1:0]            gap_q;
   logic [NBITS-1:0]            gap_cnt_q;
   logic [TW-1:0]               t_q;
   logic [NCHAN-1:0]            chan_q;
   logic                        busy_q;
   logic                        done_q;
   logic                        start_c;
   logic                        shot_end_c;
   logic                        last_shot_c;
   logic                        run_c;
   logic                        busy_c;

   // Next-state and per-cycle strobes; Stop overrides Start in IDLE and aborts RUN/GAP.
   always_comb begin
      state_d    = state_q;
      start_c    = 1'b0;
      shot_end_c = 1'b0;
      run_c      = (state_q == RUN) && !bus.Stop;
      busy_c     = ((state_q == RUN) || (state_q == GAP)) && !bus.Stop;
      case (state_q)
         IDLE: begin
            if (bus.Start && !bus.Stop) begin
               start_c = 1'b1;
               state_d = (bus.Shots == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (bus.Stop) begin
               state_d = IDLE;
            end else if (t_q == T_LAST) begin
               shot_end_c = 1'b1;
               if (last_shot_c) begin
                  state_d = DONE;
               end else if (gap_q != '0) begin
                  state_d = GAP;
               end else begin
                  state_d = RUN;
               end
            end
         end
         GAP: begin
            if (bus.Stop) begin
               state_d = IDLE;
            end else if (gap_cnt_q == NBITS'(1)) begin
               state_d = RUN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         offsets_q <= '0;
         width_q   <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         t_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start_c) begin
            mask_q    <= bus.Mask;
            offsets_q <= bus.Offsets;
            width_q   <= bus.Width;
            gap_q     <= bus.Gap;
         end
         // Timer wraps naturally at the end of a shot and rests at 0 outside RUN.
         t_q <= (state_q == RUN) ? t_q + TW'(1) : '0;
         if (shot_end_c) begin
            gap_cnt_q <= gap_q;
         end else if (state_q == GAP) begin
            gap_cnt_q <= gap_cnt_q - NBITS'(1);
         end
         busy_q <= busy_c;
         done_q <= (state_q == DONE);
      end
   end

`ifdef PULSEGEN_SHOTCNT_EN
   logic [NBITS-1:0] shots_q;
   logic [NBITS-1:0] shot_cnt_q;

   assign last_shot_c = (shot_cnt_q + NBITS'(1)) == shots_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         shots_q    <= '0;
         shot_cnt_q <= '0;
      end else if (start_c) begin
         shots_q    <= bus.Shots;
         shot_cnt_q <= '0;
      end else if (shot_end_c) begin
         shot_cnt_q <= shot_cnt_q + NBITS'(1);
      end
   end

   assign bus.ShotCount = shot_cnt_q;
`else
   logic [NBITS-1:0] remaining_q;

   assign last_shot_c = (remaining_q == NBITS'(1));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         remaining_q <= '0;
      end else if (start_c) begin
         remaining_q <= bus.Shots;
      end else if (shot_end_c) begin
         remaining_q <= remaining_q - NBITS'(1);
      end
   end

   assign bus.ShotCount = '0;
`endif

   for (genvar i = 0; i < NCHAN; i++) begin : g_chan
      pulse_window #(
         .NBITS (NBITS)
      ) u_win (
         .Clk    (Clk),
         .Rst_n  (Rst_n),
         .en     (run_c),
         .t      (t_q),
         .offset (offsets_q[i]),
         .width  (width_q),
         .mask   (mask_q[i]),
         .ch     (chan_q[i])
      );
   end

   assign bus.Channels = chan_q;
   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;

endmodule

// File: tb/tb_coincidence_pulse_gen.sv
// Scoreboard bench for coincidence_pulse_gen: per-cycle expected outputs come from a
// closed-form burst timing model; a negedge monitor pops and compares them.
module tb_coincidence_pulse_gen;

   localparam int SPAN = 32;
`ifdef PULSEGEN_SHOTCNT_EN
   localparam bit SC_EN = 1'b1;
`else
   localparam bit SC_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0] ch;
      logic       busy;
      logic       done;
      logic [3:0] sc;
   } obs_t;

   typedef struct {
      int   cyc;
      obs_t o;
   } exp_t;

   logic Clk   = 1'b0;
   logic Rst_n = 1'b1;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   logic [3:0] mask_m;
   int         off_m[4];
   int         width_m;
   int         gap_m;
   int         shots_m;
   int         stop_m;
   logic [3:0] last_sc;

   coincidence_pulse_gen_if #(.NCHAN(4), .NBITS(4)) bus ();

   coincidence_pulse_gen #(.NCHAN(4), .NBITS(4)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic obs_t observe();
      return {bus.Channels, bus.Busy, bus.Done, bus.ShotCount};
   endfunction

   // Shots completed by the edge S+c: shot k ends at edge S+SPAN+k*(SPAN+gap).
   function automatic int sc_at(input int c);
      int n;
      if (c < SPAN) n = 0;
      else n = (c - SPAN) / (SPAN + gap_m) + 1;
      if (n > shots_m) n = shots_m;
      return n;
   endfunction

   // Expected outputs just after edge S+c of a burst whose Start is sampled at edge S.
   function automatic obs_t model(input int c);
      obs_t o;
      int   d;
      int   r;
      o = '0;
      d = (shots_m == 0) ? 1 : 1 + shots_m * SPAN + (shots_m - 1) * gap_m;
      if (stop_m > 0 && c >= stop_m) begin
         o.sc = SC_EN ? 4'(sc_at(stop_m - 1)) : 4'd0;
         return o;
      end
      if (c >= 1 && c < d) begin
         o.busy = 1'b1;
         r = (c - 1) % (SPAN + gap_m);
         if (r < SPAN)
            for (int i = 0; i < 4; i++)
               o.ch[i] = mask_m[i] && (r >= off_m[i]) && (r < off_m[i] + width_m);
      end
      o.done = (c == d);
      o.sc   = SC_EN ? 4'(sc_at(c)) : 4'd0;
      return o;
   endfunction

   task automatic check_obs(input string name, input int at, input obs_t got, input obs_t want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s @cycle %0d: got ch=%b busy=%b done=%b sc=%0d, want ch=%b busy=%b done=%b sc=%0d",
                  name, at, got.ch, got.busy, got.done, got.sc, want.ch, want.busy, want.done, want.sc);
      end
   endtask

   task automatic set_params(input logic [3:0] m, input int o0, input int o1, input int o2,
                             input int o3, input int w, input int g, input int n);
      mask_m  = m;
      off_m[0] = o0; off_m[1] = o1; off_m[2] = o2; off_m[3] = o3;
      width_m = w;
      gap_m   = g;
      shots_m = n;
   endtask

   // Called just after a rising edge; returns just after edge S+last+tail.
   task automatic run_burst(input int stop_at, input int cut, input int tail, input bit noise);
      int   s, d, last;
      exp_t e;
      stop_m = stop_at;
      d = (shots_m == 0) ? 1 : 1 + shots_m * SPAN + (shots_m - 1) * gap_m;
      last = (cut > 0) ? cut : (stop_at > 0) ? stop_at : d;
      bus.Mask  = mask_m;
      for (int i = 0; i < 4; i++) bus.Offsets[i] = 4'(off_m[i]);
      bus.Width = 4'(width_m);
      bus.Gap   = 4'(gap_m);
      bus.Shots = 4'(shots_m);
      bus.Start = 1'b1;
      bus.Stop  = 1'b0;
      s = cyc + 1;
      for (int c = 0; c <= last + tail; c++) begin
         e.cyc = s + c;
         e.o   = model(c);
         sb.push_back(e);
      end
      while (cyc < s + last + tail) begin
         @(posedge Clk);
         #1;
         bus.Start = 1'b0;
         bus.Stop  = 1'b0;
         if (noise && cyc < s + last) begin
            bus.Mask    = 4'($urandom);
            bus.Offsets = 16'($urandom);
            bus.Width   = 4'($urandom);
            bus.Gap     = 4'($urandom);
            bus.Shots   = 4'($urandom);
            bus.Start   = 1'($urandom);
         end
         if (stop_at > 0 && cyc == s + stop_at - 1) bus.Stop = 1'b1;
         if (noise && stop_at == 0 && cyc == s + last - 1) bus.Stop = 1'($urandom);
      end
      last_sc = model(last + tail).sc;
   endtask

   // Start and Stop together in IDLE: nothing starts and ShotCount holds.
   task automatic idle_check(input int n);
      int   s;
      exp_t e;
      e.o    = '0;
      e.o.sc = last_sc;
      bus.Start = 1'b1;
      bus.Stop  = 1'b1;
      s = cyc + 1;
      for (int c = 0; c < n; c++) begin
         e.cyc = s + c;
         sb.push_back(e);
      end
      while (cyc < s + n - 1) begin
         @(posedge Clk);
         #1;
         bus.Start = 1'b0;
         bus.Stop  = 1'b0;
      end
   endtask

   initial begin
      bus.Start = 1'b0; bus.Stop = 1'b0; bus.Mask = '0; bus.Offsets = '0;
      bus.Width = '0;   bus.Gap = '0;    bus.Shots = '0;
      last_sc = '0;
      stop_m  = 0;

      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge Clk);
               if (sb.size() > 0 && sb[0].cyc == cyc) begin
                  e = sb.pop_front();
                  check_obs("cycle", e.cyc, observe(), e.o);
               end
            end
         end
         begin : watchdog
            repeat (20000) @(posedge Clk);
            $display("FAIL watchdog: simulation ran past its cycle budget");
            $fatal(1, "watchdog expired");
         end
      join_none

      #1 Rst_n = 1'b0;
      #2 check_obs("reset", cyc, observe(), '0);
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;

      set_params(4'b1111, 0, 0, 0, 0, 5, 0, 0);      // Shots=0: Done only, no Busy
      run_burst(0, 0, 3, 1'b0);
      set_params(4'b0011, 0, 0, 9, 9, 3, 0, 1);      // simple 3-cycle pulse on ch0/ch1
      run_burst(0, 0, 2, 1'b0);
      set_params(4'b0101, 2, 7, 15, 3, 15, 0, 1);    // overlapping windows, max offset+width
      run_burst(0, 0, 2, 1'b0);
      set_params(4'b0001, 0, 4, 4, 4, 1, 5, 3);      // three shots with gap
      run_burst(0, 0, 2, 1'b0);
      set_params(4'b1111, 0, 3, 10, 12, 8, 3, 4);    // Stop at t=10 of the second shot
      run_burst(SPAN + 3 + 11, 0, 0, 1'b0);
      set_params(4'b1010, 1, 5, 9, 14, 6, 2, 2);     // restart on the cycle after Stop
      run_burst(0, 0, 2, 1'b0);
      idle_check(5);
      set_params(4'($urandom), 0, 6, 11, 15, 1 + int'($urandom_range(0, 14)), 0, 15);
      run_burst(0, 0, 1, 1'b1);                       // longest burst, inputs churned

      for (int k = 0; k < 8; k++) begin
         set_params(4'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 3)));
         run_burst(0, 0, int'($urandom_range(0, 3)), 1'b1);
      end

      set_params(4'b1111, 0, 0, 0, 0, 15, 2, 2);      // reset mid-shot while all channels high
      run_burst(0, 4, 0, 1'b0);
      @(posedge Clk);
      #3 Rst_n = 1'b0;
      #1 check_obs("async_reset", cyc, observe(), '0);
      repeat (2) @(posedge Clk);
      #1 Rst_n = 1'b1;
      last_sc = '0;
      set_params(4'b0110, 3, 0, 30 - 16, 8, 4, 1, 2);
      run_burst(0, 0, 2, 1'b0);

      repeat (3) @(posedge Clk);
      #1;
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expected samples left unchecked, want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
